// File: rtl/mc_core_pkg.sv
// mc_core shared definitions: RV32I-subset encodings,
// sequencer states, ALU operations and immediate formats.
package mc_core_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;

  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SLT = 3'd2;
  localparam logic [2:0] F3_OR  = 3'd6;
  localparam logic [2:0] F3_AND = 3'd7;
  localparam logic [2:0] F3_BEQ = 3'd0;
  localparam logic [2:0] F3_BNE = 3'd1;
  localparam logic [2:0] F3_BLT = 3'd4;
  localparam logic [2:0] F3_W   = 3'd2;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h20;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_PASSB
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_J, IMM_U
  } imm_type_e;

  function automatic alu_op_e f3_alu(logic [2:0] f3);
    alu_op_e op;
    unique case (f3)
      F3_SLT:  op = ALU_SLT;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic f3_alu_ok(logic [2:0] f3);
    return f3 inside {F3_ADD, F3_SLT, F3_OR, F3_AND};
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: NREG x XLEN registers, two async read
// ports, one sync write port, x0 and out-of-range read 0.
module mc_regfile
  import mc_core_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [4:0]      ra1_i,
  input  logic [4:0]      ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  input  logic            we_i,
  input  logic [4:0]      wa_i,
  input  logic [XLEN-1:0] wd_i
);

  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];

  // no bypass: a read in the write cycle sees the old value
  assign rd1_o = (32'(ra1_i) < NREG && ra1_i != 5'd0)
               ? regs_q[ra1_i[AW-1:0]] : '0;
  assign rd2_o = (32'(ra2_i) < NREG && ra2_i != 5'd0)
               ? regs_q[ra2_i[AW-1:0]] : '0;

  // write port; entry 0 never written, out-of-range dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++)
        if (we_i && 32'(wa_i) == i) regs_q[i] <= wd_i;
    end
  end

endmodule

// File: rtl/mc_core.sv
// mc_core: multi-cycle RV32I-subset core, one memory port.
// Define MC_CORE_TRAP_EN to halt on illegal/misaligned ops.
module mc_core
  import mc_core_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            retire,
  output logic [XLEN-1:0] pc_dbg,
  output logic            halted
);

`ifdef MC_CORE_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, old_pc_q, old_pc_d;
  logic [31:0] ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic is_r, is_i, is_ld, is_st, is_br;
  logic is_jal, is_jalr, is_lui, is_ebrk;
  logic legal, use_imm, take;
  imm_type_e imm_sel;
  alu_op_e alu_op;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [XLEN-1:0] imm, alu_b, alu_res, jalr_tgt;
  logic [XLEN-1:0] rs1_val, rs2_val, rf_wd, addr_c;
  logic rf_we, req_c, we_c, retire_c;

  assign opcode = ir_q[6:0];
  assign f3 = ir_q[14:12];
  assign f7 = ir_q[31:25];

  assign is_r    = opcode == OP_R;
  assign is_i    = opcode == OP_I;
  assign is_ld   = opcode == OP_LOAD;
  assign is_st   = opcode == OP_STORE;
  assign is_br   = opcode == OP_BRANCH;
  assign is_jal  = opcode == OP_JAL;
  assign is_jalr = opcode == OP_JALR;
  assign is_lui  = opcode == OP_LUI;
  assign is_ebrk = ir_q == EBREAK;

  assign imm_i = XLEN'($signed(ir_q[31:20]));
  assign imm_s = XLEN'($signed({ir_q[31:25], ir_q[11:7]}));
  assign imm_b = XLEN'($signed({ir_q[31], ir_q[7],
                 ir_q[30:25], ir_q[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({ir_q[31], ir_q[19:12],
                 ir_q[20], ir_q[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({ir_q[31:12], 12'b0}));

  mc_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk_i (clk),
    .rst_ni(reset),
    .ra1_i (ir_q[19:15]),
    .ra2_i (ir_q[24:20]),
    .rd1_o (rs1_val),
    .rd2_o (rs2_val),
    .we_i  (rf_we),
    .wa_i  (ir_q[11:7]),
    .wd_i  (rf_wd)
  );

  // instruction class -> legality, ALU op, immediate format
  always_comb begin
    legal = 1'b0;
    use_imm = 1'b1;
    imm_sel = IMM_I;
    alu_op = ALU_ADD;
    unique case (1'b1)
      is_r: begin
        legal = (f7 == F7_BASE && f3_alu_ok(f3)) ||
                (f7 == F7_SUB && f3 == F3_ADD);
        use_imm = 1'b0;
        alu_op = (f7 == F7_SUB) ? ALU_SUB : f3_alu(f3);
      end
      is_i: begin
        legal = f3_alu_ok(f3);
        alu_op = f3_alu(f3);
      end
      is_ld: legal = f3 == F3_W;
      is_st: begin
        legal = f3 == F3_W;
        imm_sel = IMM_S;
      end
      is_br: begin
        legal = f3 inside {F3_BEQ, F3_BNE, F3_BLT};
        imm_sel = IMM_B;
      end
      is_jal: begin
        legal = 1'b1;
        imm_sel = IMM_J;
      end
      is_jalr: legal = f3 == F3_ADD;
      is_lui: begin
        legal = 1'b1;
        imm_sel = IMM_U;
        alu_op = ALU_PASSB;
      end
      is_ebrk: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // immediate select, ALU and branch compare
  always_comb begin
    unique case (imm_sel)
      IMM_S:   imm = imm_s;
      IMM_B:   imm = imm_b;
      IMM_J:   imm = imm_j;
      IMM_U:   imm = imm_u;
      default: imm = imm_i;
    endcase
    alu_b = use_imm ? imm : b_q;
    unique case (alu_op)
      ALU_SUB:   alu_res = a_q - alu_b;
      ALU_AND:   alu_res = a_q & alu_b;
      ALU_OR:    alu_res = a_q | alu_b;
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}},
                   $signed(a_q) < $signed(alu_b)};
      ALU_PASSB: alu_res = alu_b;
      default:   alu_res = a_q + alu_b;
    endcase
    jalr_tgt = {alu_res[XLEN-1:1], 1'b0};
    unique case (f3)
      F3_BEQ:  take = a_q == b_q;
      F3_BNE:  take = a_q != b_q;
      F3_BLT:  take = $signed(a_q) < $signed(b_q);
      default: take = 1'b0;
    endcase
  end

  // sequencer: next state, datapath loads, memory port
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    old_pc_d = old_pc_q;
    ir_d = ir_q;
    a_d = a_q;
    b_d = b_q;
    alu_d = alu_q;
    req_c = 1'b0;
    we_c = 1'b0;
    addr_c = pc_q;
    retire_c = 1'b0;
    rf_we = 1'b0;
    rf_wd = alu_q;
    unique case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          ir_d = mem_rdata[31:0];
          old_pc_d = pc_q;
          pc_d = pc_q + XLEN'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = rs1_val;
        b_d = rs2_val;
        alu_d = old_pc_q + (is_jal ? imm_j : imm_b);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_d = alu_res;
        state_d = S_WB;
        if (!legal) begin
          retire_c = !TrapEn;
          state_d = TrapEn ? S_HALT : S_FETCH;
        end else if (is_ebrk) begin
          retire_c = 1'b1;
          state_d = S_HALT;
        end else if (is_br) begin
          retire_c = 1'b1;
          alu_d = alu_q;
          state_d = S_FETCH;
          if (take) pc_d = alu_q;
        end else if (is_ld || is_st) begin
          state_d = (TrapEn && alu_res[1:0] != 2'b0)
                  ? S_HALT : S_MEM;
        end else if (is_jal) begin
          if (TrapEn && alu_q[1:0] != 2'b0) state_d = S_HALT;
          else pc_d = alu_q;
        end else if (is_jalr) begin
          if (TrapEn && jalr_tgt[1:0] != 2'b0) state_d = S_HALT;
          else pc_d = jalr_tgt;
        end
      end
      S_MEM: begin
        req_c = 1'b1;
        we_c = is_st;
        addr_c = alu_q;
        if (mem_ready) begin
          if (is_st) begin
            retire_c = 1'b1;
            state_d = S_FETCH;
          end else begin
            // load data reuses ALUout on its way to WB
            alu_d = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        rf_wd = (is_jal || is_jalr) ? old_pc_q + XLEN'(4) : alu_q;
        retire_c = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // architectural and sequencer state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q <= RESET_PC;
      old_pc_q <= '0;
      ir_q <= '0;
      a_q <= '0;
      b_q <= '0;
      alu_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      old_pc_q <= old_pc_d;
      ir_q <= ir_d;
      a_q <= a_d;
      b_q <= b_d;
      alu_q <= alu_d;
    end
  end

  // reset kills an in-flight request in the same cycle
  assign mem_req = req_c & reset;
  assign mem_we = we_c;
  assign mem_addr = TrapEn ? addr_c : {addr_c[XLEN-1:2], 2'b00};
  assign mem_wdata = b_q;
  assign retire = retire_c;
  assign pc_dbg = pc_q;
  assign halted = state_q == S_HALT;

endmodule

// File: tb/tb_mc_core.sv
// tb_mc_core: directed programs against mc_core with a
// wait-state memory model on the 0x40..0x7F data window.
module tb_mc_core;
  import mc_core_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

  logic [31:0] rom [32];
  logic [31:0] ram [16];
  int dwait = 0;
  int wcnt = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic data_acc;

  logic prev_stall = 1'b0;
  logic [31:0] cap_addr, cap_wdata;
  logic cap_we;

  always #5 clk = ~clk;

  mc_core #(.XLEN(32), .NREG(32), .RESET_PC(32'h0)) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .retire   (retire),
    .pc_dbg   (pc_dbg),
    .halted   (halted)
  );

  assign data_acc = mem_addr >= 32'h40 && mem_addr < 32'h80;
  assign mem_ready = mem_req && (!data_acc || wcnt >= dwait);
  assign mem_rdata = data_acc ? ram[mem_addr[5:2]]
                              : rom[mem_addr[6:2]];

  always @(posedge clk) begin
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (mem_req && mem_ready && mem_we && data_acc)
      ram[mem_addr[5:2]] <= mem_wdata;
  end

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && mem_req && prev_stall) begin
      chk("stall_addr", mem_addr, cap_addr);
      chk("stall_wdata", mem_wdata, cap_wdata);
      chk("stall_we", 32'(mem_we), 32'(cap_we));
    end
    prev_stall = reset && mem_req && !mem_ready;
    cap_addr = mem_addr;
    cap_wdata = mem_wdata;
    cap_we = mem_we;
  end

  function automatic logic [31:0] reg_val(int i);
    return dut.u_rf.regs_q[i];
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm,
      logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd,
      logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7,
      logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3,
      logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_R};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm,
      logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, F3_W, imm[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] imm,
      logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1],
            imm[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(logic [20:0] imm,
      logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

  function automatic logic [31:0] addi(logic [4:0] rd,
      logic [4:0] rs1, logic [11:0] imm);
    return enc_i(imm, rs1, F3_ADD, rd, OP_I);
  endfunction

  task automatic wait_retire(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!retire && n < 40);
  endtask

  // retire after cyc cycles, then rd / pc as given
  task automatic step(string tag, int cyc, int rd,
                      logic [31:0] val, logic [31:0] pc);
    int n;
    wait_retire(n);
    chk({tag, "_cycles"}, 32'(n), 32'(cyc));
    @(posedge clk);
    #1;
    if (rd >= 0) chk({tag, "_rd"}, reg_val(rd), val);
    chk({tag, "_pc"}, pc_dbg, pc);
  endtask

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = '0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    int rcnt;
    int qcnt;
    logic found;

    // program A: arithmetic, then store/load with waits
    clear_rom();
    rom[0] = addi(5'd1, 5'd0, 12'd5);
    rom[1] = addi(5'd2, 5'd0, 12'd7);
    rom[2] = enc_r(F7_BASE, 5'd2, 5'd1, F3_ADD, 5'd3);
    rom[3] = enc_s(12'h040, 5'd3, 5'd0);
    rom[4] = enc_i(12'h040, 5'd0, F3_W, 5'd4, OP_LOAD);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", pc_dbg, 32'h0);
    chk("rst_x1", reg_val(1), 32'h0);
    #1 reset = 1'b1;
    step("addi1", 4, 1, 32'd5, 32'h4);
    step("addi2", 4, 2, 32'd7, 32'h8);
    step("add", 4, 3, 32'd12, 32'hC);
    dwait = 3;
    step("sw", 7, -1, 32'h0, 32'h10);
    chk("sw_mem", ram[0], 32'd12);
    step("lw", 8, 4, 32'd12, 32'h14);

    // program B: branches and jumps
    reset = 1'b0;
    dwait = 0;
    clear_rom();
    rom[0]  = addi(5'd1, 5'd0, 12'd5);
    rom[1]  = enc_b(13'd8, 5'd1, 5'd1, F3_BEQ);
    rom[2]  = addi(5'd9, 5'd0, 12'd1);
    rom[3]  = enc_b(13'd8, 5'd1, 5'd1, F3_BNE);
    rom[4]  = enc_j(21'd16, 5'd0);
    rom[8]  = enc_j(21'd16, 5'd5);
    rom[12] = enc_i(12'd3, 5'd5, F3_ADD, 5'd6, OP_JALR);
    release_reset();
    step("addi_b", 4, 1, 32'd5, 32'h4);
    step("beq_taken", 3, -1, 32'h0, 32'hC);
    step("bne_not", 3, -1, 32'h0, 32'h10);
    step("jal_x0", 4, -1, 32'h0, 32'h20);
    step("jal_x5", 4, 5, 32'h24, 32'h30);
`ifdef MC_CORE_TRAP_EN
    rcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (retire) rcnt++;
    end
    chk("jalr_trap_retire", 32'(rcnt), 32'd0);
    chk("jalr_trap_halt", 32'(halted), 32'd1);
    chk("jalr_trap_pc", pc_dbg, 32'h34);
    chk("jalr_trap_x6", reg_val(6), 32'h0);
`else
    step("jalr", 4, 6, 32'h34, 32'h26);
    chk("jalr_fetch_addr", mem_addr, 32'h24);
    chk("jalr_fetch_req", 32'(mem_req), 32'd1);
`endif
    chk("skipped_x9", reg_val(9), 32'h0);

    // program C: x0, wrap, signed compare, reset mid-load
    reset = 1'b0;
    dwait = 3;
    clear_rom();
    rom[0] = addi(5'd7, 5'd0, 12'd3);
    rom[1] = addi(5'd0, 5'd0, 12'd9);
    rom[2] = enc_r(F7_BASE, 5'd0, 5'd0, F3_ADD, 5'd7);
    rom[3] = addi(5'd1, 5'd0, 12'd1);
    rom[4] = enc_r(F7_SUB, 5'd1, 5'd0, F3_ADD, 5'd8);
    rom[5] = addi(5'd2, 5'd0, 12'hFFF);
    rom[6] = enc_r(F7_BASE, 5'd1, 5'd2, F3_SLT, 5'd9);
    rom[7] = enc_b(13'd8, 5'd1, 5'd2, F3_BLT);
    rom[8] = addi(5'd10, 5'd0, 12'd1);
    rom[9] = enc_i(12'h040, 5'd0, F3_W, 5'd11, OP_LOAD);
    release_reset();
    step("set_x7", 4, 7, 32'd3, 32'h4);
    step("addi_x0", 4, 0, 32'h0, 32'h8);
    step("add_x0", 4, 7, 32'h0, 32'hC);
    step("set_x1", 4, 1, 32'd1, 32'h10);
    step("sub_wrap", 4, 8, 32'hFFFF_FFFF, 32'h14);
    step("set_m1", 4, 2, 32'hFFFF_FFFF, 32'h18);
    step("slt_neg", 4, 9, 32'd1, 32'h1C);
    step("blt_taken", 3, -1, 32'h0, 32'h24);
    chk("blt_skip_x10", reg_val(10), 32'h0);

    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_req && !mem_ready && mem_addr == 32'h40)
        found = 1'b1;
    end
    chk("ld_stall_seen", 32'(found), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_drop_req", 32'(mem_req), 32'd0);
    chk("rst_mid_pc", pc_dbg, 32'h0);
    chk("rst_mid_retire", 32'(retire), 32'd0);
    chk("rst_mid_x9", reg_val(9), 32'h0);

    // program D: ebreak at the reset vector
    dwait = 0;
    clear_rom();
    rom[0] = EBREAK;
    release_reset();
    #1;
    chk("refetch_req", 32'(mem_req), 32'd1);
    chk("refetch_addr", mem_addr, 32'h0);
    step("ebreak", 3, -1, 32'h0, 32'h4);
    chk("ebreak_halted", 32'(halted), 32'd1);
    rcnt = 0;
    qcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (retire) rcnt++;
      if (mem_req) qcnt++;
    end
    chk("halt_no_retire", 32'(rcnt), 32'd0);
    chk("halt_no_req", 32'(qcnt), 32'd0);
    chk("halt_sticky", 32'(halted), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
